// File: rtl/ibus_axi3_cache_if.sv
// Bus bundles for the instruction cache.
//   cpu_ibus_if : CPU fetch port (request, flush kills, invalidate, response).
//                 slave modport = cache side, master modport = CPU side.
//   axi3_rd_if  : AXI3 master port. Only the read channels carry traffic; the
//                 write channels exist for bus uniformity.
//                 master modport = cache side, slave modport = memory side.
interface cpu_ibus_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]           ibus_addr;
  logic                  ibus_read;
  logic                  ibus_flush_1;
  logic                  ibus_flush_2;
  logic                  ibus_flush_3;
  logic                  ibus_ready;
  logic                  ibus_stall;
  logic [DATA_WIDTH-1:0] ibus_rddata;
  logic                  ibus_rddata_vld;
  logic                  inv_icache;
  logic [31:0]           inv_addr;

  modport master (
    output ibus_addr, ibus_read, ibus_flush_1, ibus_flush_2, ibus_flush_3,
           inv_icache, inv_addr,
    input  ibus_ready, ibus_stall, ibus_rddata, ibus_rddata_vld
  );
  modport slave (
    input  ibus_addr, ibus_read, ibus_flush_1, ibus_flush_2, ibus_flush_3,
           inv_icache, inv_addr,
    output ibus_ready, ibus_stall, ibus_rddata, ibus_rddata_vld
  );
endinterface

interface axi3_rd_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [3:0]              arid;
  logic [31:0]             araddr;
  logic [3:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [1:0]              arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [3:0]              rid;
  logic [1:0]              rresp;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  logic [3:0]              awid;
  logic [31:0]             awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [1:0]              awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [3:0]              wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [3:0]              bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
           rready, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rresp, rdata, rlast, rvalid, awready, wready, bid, bresp,
           bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
           rready, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rresp, rdata, rlast, rvalid, awready, wready, bid, bresp,
           bvalid
  );
endinterface

// File: rtl/ibus_axi3_cache.sv
// Blocking, set-associative, read-only instruction cache.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   ibus : cpu_ibus_if.slave  - fetch requests, flush kills, line invalidate
//   axi  : axi3_rd_if.master  - one INCR line refill burst per miss; write idle
// Hits answer the cycle after acceptance; misses stall until the line is filled.
module ibus_axi3_cache #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned SET_ASSOC  = 4,
  parameter int unsigned CACHE_SIZE = 131072,
  parameter logic [3:0]  ARID       = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  cpu_ibus_if.slave   ibus,
  axi3_rd_if.master   axi
);
  localparam int unsigned WORDS  = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned SETS   = CACHE_SIZE / (LINE_WIDTH * SET_ASSOC);
  localparam int unsigned BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WORD_W = $clog2(WORDS);
  localparam int unsigned OFF_W  = BYTE_W + WORD_W;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
  localparam int unsigned WAY_W  = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_REFILL, S_FILL_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    ready_q;
  logic                    kill_q, kill_d;
  logic [WORD_W-1:0]       beat_q, beat_d;
  logic [LINE_WIDTH-1:0]   linebuf_q, linebuf_d;
  logic [31:0]             req_addr_q;

  logic [SET_ASSOC-1:0]    valid_q  [SETS];
  logic [WAY_W-1:0]        victim_q [SETS];
  logic [TAG_W-1:0]        tag_q    [SETS][SET_ASSOC];
  logic [LINE_WIDTH-1:0]   data_q   [SETS][SET_ASSOC];

  logic [IDX_W-1:0]        req_idx, inv_idx;
  logic [TAG_W-1:0]        req_tag, inv_tag;
  logic [WORD_W-1:0]       req_word;
  logic                    hit, stall, accept, flush, fill_done, vld;
  logic [WAY_W-1:0]        hit_way, victim_nxt;
  logic [DATA_WIDTH-1:0]   word;
  logic [LINE_WIDTH-1:0]   fill_line;
  logic [SET_ASSOC-1:0]    inv_hit;
  logic                    unused_ok;

  assign req_idx  = req_addr_q[OFF_W +: IDX_W];
  assign req_tag  = req_addr_q[31 -: TAG_W];
  assign req_word = req_addr_q[BYTE_W +: WORD_W];
  assign inv_idx  = ibus.inv_addr[OFF_W +: IDX_W];
  assign inv_tag  = ibus.inv_addr[31 -: TAG_W];
  assign flush    = ibus.ibus_flush_1 | ibus.ibus_flush_2 | ibus.ibus_flush_3;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < SET_ASSOC; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Stall covers the miss-detect cycle too, so nothing is accepted once a miss is seen.
  assign stall     = (state_q == S_LOOKUP && !hit) || state_q == S_AR || state_q == S_REFILL;
  assign accept    = ibus.ibus_read && ready_q && !stall;
  assign fill_done = state_q == S_REFILL && axi.rvalid && axi.rlast;
  assign victim_nxt = (victim_q[req_idx] == WAY_W'(SET_ASSOC - 1)) ? '0 : victim_q[req_idx] + WAY_W'(1);

  always_comb begin
    fill_line = linebuf_q;
    fill_line[int'(beat_q) * DATA_WIDTH +: DATA_WIDTH] = axi.rdata;
  end

  // The way being filled this cycle is matched against its new tag so a
  // same-cycle invalidate of that line wins over the fill.
  always_comb begin
    inv_hit = '0;
    for (int unsigned w = 0; w < SET_ASSOC; w++) begin
      if (fill_done && inv_idx == req_idx && victim_q[req_idx] == WAY_W'(w))
        inv_hit[w] = (req_tag == inv_tag);
      else
        inv_hit[w] = (tag_q[inv_idx][w] == inv_tag);
    end
  end

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    beat_d      = beat_q;
    linebuf_d   = linebuf_q;
    vld         = 1'b0;
    word        = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit) begin
          vld     = !flush;
          word    = data_q[req_idx][hit_way][int'(req_word) * DATA_WIDTH +: DATA_WIDTH];
          state_d = accept ? S_LOOKUP : S_IDLE;
        end else begin
          // Address phase starts in the miss-detect cycle to save one cycle.
          axi.arvalid = 1'b1;
          kill_d      = flush;
          beat_d      = '0;
          state_d     = axi.arready ? S_REFILL : S_AR;
        end
      end
      S_AR: begin
        axi.arvalid = 1'b1;
        if (flush) kill_d = 1'b1;
        if (axi.arready) state_d = S_REFILL;
      end
      S_REFILL: begin
        axi.rready = 1'b1;
        if (flush) kill_d = 1'b1;
        if (axi.rvalid) begin
          linebuf_d = fill_line;
          beat_d    = beat_q + WORD_W'(1);
          if (axi.rlast) state_d = S_FILL_RESP;
        end
      end
      S_FILL_RESP: begin
        vld     = !kill_q && !flush;
        word    = linebuf_q[int'(req_word) * DATA_WIDTH +: DATA_WIDTH];
        // Not stalled here, so a new request may already be accepted.
        state_d = accept ? S_LOOKUP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      kill_q  <= 1'b0;
      beat_q  <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      kill_q  <= kill_d;
      beat_q  <= beat_d;
      if (fill_done) begin
        valid_q[req_idx][victim_q[req_idx]] <= 1'b1;
        victim_q[req_idx]                   <= victim_nxt;
      end
      for (int unsigned w = 0; w < SET_ASSOC; w++) begin
        if (ibus.inv_icache && inv_hit[w]) valid_q[inv_idx][w] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    linebuf_q <= linebuf_d;
    if (accept) req_addr_q <= ibus.ibus_addr;
    if (fill_done) begin
      tag_q[req_idx][victim_q[req_idx]]  <= req_tag;
      data_q[req_idx][victim_q[req_idx]] <= fill_line;
    end
  end

  assign ibus.ibus_ready      = ready_q;
  assign ibus.ibus_stall      = stall;
  assign ibus.ibus_rddata_vld = vld;
  assign ibus.ibus_rddata     = vld ? word : '0;

  assign axi.arid    = ARID;
  assign axi.araddr  = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign axi.arlen   = 4'(WORDS - 1);
  assign axi.arsize  = 3'(BYTE_W);
  assign axi.arburst = 2'b01;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;

  assign axi.awid    = '0;
  assign axi.awaddr  = '0;
  assign axi.awlen   = '0;
  assign axi.awsize  = '0;
  assign axi.awburst = '0;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = 1'b0;
  assign axi.wid     = '0;
  assign axi.wdata   = '0;
  assign axi.wstrb   = '0;
  assign axi.wlast   = 1'b0;
  assign axi.wvalid  = 1'b0;
  assign axi.bready  = 1'b1;

  assign unused_ok = ^{axi.rid, axi.rresp, axi.awready, axi.wready, axi.bid, axi.bresp,
                       axi.bvalid, req_addr_q[BYTE_W-1:0], ibus.inv_addr[OFF_W-1:0]};
endmodule

// File: tb/tb_ibus_axi3_cache.sv
// Self-checking bench for ibus_axi3_cache: the bench plays CPU and AXI memory,
// and predicts hit/miss and data from a per-set slot/round-robin cache model.
module tb_ibus_axi3_cache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_ibus_if #(.DATA_WIDTH(32)) cpu ();
  axi3_rd_if  #(.DATA_WIDTH(32)) axi_bus ();

  ibus_axi3_cache #(
    .DATA_WIDTH(32), .LINE_WIDTH(256), .SET_ASSOC(4), .CACHE_SIZE(131072), .ARID(4'd0)
  ) dut (
    .clk(clk), .rst(rst), .ibus(cpu), .axi(axi_bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_bursts = 0;
  logic [31:0] salt = 32'h0;

  bit          m_valid [128][4];
  logic [19:0] m_tag   [128][4];
  int unsigned m_rr    [128];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ salt;
  endfunction

  function automatic int m_find(input logic [31:0] a);
    int unsigned s = int'(a[11:5]);
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[31:12]) return w;
    return -1;
  endfunction

  task automatic m_fill(input logic [31:0] a);
    int unsigned s = int'(a[11:5]);
    int unsigned w = m_rr[s];
    m_valid[s][w] = 1'b1;
    m_tag[s][w]   = a[31:12];
    m_rr[s]       = (w + 1) % 4;
  endtask

  task automatic m_inv(input logic [31:0] a);
    int unsigned s = int'(a[11:5]);
    for (int w = 0; w < 4; w++)
      if (m_tag[s][w] == a[31:12]) m_valid[s][w] = 1'b0;
  endtask

  task automatic m_reset;
    for (int s = 0; s < 128; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    cpu.ibus_addr = '0; cpu.ibus_read = 0;
    cpu.ibus_flush_1 = 0; cpu.ibus_flush_2 = 0; cpu.ibus_flush_3 = 0;
    cpu.inv_icache = 0; cpu.inv_addr = '0;
    axi_bus.arready = 0; axi_bus.rid = '0; axi_bus.rresp = '0; axi_bus.rdata = '0;
    axi_bus.rlast = 0; axi_bus.rvalid = 0; axi_bus.awready = 0; axi_bus.wready = 0;
    axi_bus.bid = '0; axi_bus.bresp = '0; axi_bus.bvalid = 0;
  endtask

  task automatic apply_reset;
    drive_idle();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    m_reset();
  endtask

  // One fetch: the bench follows whatever path the DUT takes (hit or refill)
  // so it never hangs, and compares that path against the model's prediction.
  task automatic do_read(input logic [31:0] a, input int flush_beat, input bit inv_last);
    bit exp_hit, killed;
    logic [31:0] base;
    int unsigned w, k;
    exp_hit = (m_find(a) >= 0);
    base = a & ~32'h1F;
    killed = 1'b0;
    k = 0;
    while (!(cpu.ibus_ready === 1'b1 && cpu.ibus_stall === 1'b0) && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (!(cpu.ibus_ready === 1'b1 && cpu.ibus_stall === 1'b0)) begin
      n_err++;
      $display("FAIL ready_wait addr=%h ready=%b stall=%b required ready=1 stall=0",
               a, cpu.ibus_ready, cpu.ibus_stall);
    end
    cpu.ibus_addr = a;
    cpu.ibus_read = 1'b1;
    tick();
    cpu.ibus_read = 1'b0;
    cpu.ibus_addr = $urandom;
    w = $urandom_range(0, 3);
    axi_bus.arready = (w == 0);
    #1;
    n_cmp++;
    if (cpu.ibus_stall !== (exp_hit ? 1'b0 : 1'b1)) begin
      n_err++;
      $display("FAIL hit_miss addr=%h stall=%b required=%b", a, cpu.ibus_stall, !exp_hit);
    end
    if (cpu.ibus_stall !== 1'b1) begin
      n_cmp++;
      if (cpu.ibus_rddata_vld !== 1'b1 || cpu.ibus_rddata !== mem_word(a)) begin
        n_err++;
        $display("FAIL hit_data addr=%h vld=%b data=%h required vld=1 data=%h",
                 a, cpu.ibus_rddata_vld, cpu.ibus_rddata, mem_word(a));
      end
      axi_bus.arready = 1'b0;
    end else begin
      n_bursts++;
      n_cmp++;
      if (axi_bus.arvalid !== 1'b1 || axi_bus.araddr !== base || axi_bus.arlen !== 4'd7 ||
          axi_bus.arsize !== 3'd2 || axi_bus.arburst !== 2'd1 || axi_bus.arid !== 4'd0) begin
        n_err++;
        $display("FAIL ar_fields addr=%h arvalid=%b araddr=%h arlen=%0d arsize=%0d arburst=%0d required 1 %h 7 2 1",
                 a, axi_bus.arvalid, axi_bus.araddr, axi_bus.arlen, axi_bus.arsize,
                 axi_bus.arburst, base);
      end
      for (int unsigned i = 1; i <= w; i++) begin
        tick();
        axi_bus.arready = (i == w);
        #1;
        n_cmp++;
        if (axi_bus.arvalid !== 1'b1) begin
          n_err++;
          $display("FAIL ar_hold addr=%h arvalid=%b required=1", a, axi_bus.arvalid);
        end
      end
      tick();
      axi_bus.arready = 1'b0;
      for (int unsigned b = 0; b < 8; b++) begin
        repeat ($urandom_range(0, 2)) begin
          axi_bus.rvalid = 1'b0;
          #1;
          n_cmp++;
          if (cpu.ibus_stall !== 1'b1 || cpu.ibus_rddata_vld !== 1'b0) begin
            n_err++;
            $display("FAIL refill_gap addr=%h stall=%b vld=%b required stall=1 vld=0",
                     a, cpu.ibus_stall, cpu.ibus_rddata_vld);
          end
          tick();
        end
        axi_bus.rvalid = 1'b1;
        axi_bus.rdata  = mem_word(base + 32'(4 * b));
        axi_bus.rlast  = (b == 7);
        cpu.ibus_flush_2 = (int'(b) == flush_beat);
        if (int'(b) == flush_beat) killed = 1'b1;
        if (inv_last && b == 7) begin
          cpu.inv_icache = 1'b1;
          cpu.inv_addr   = a;
        end
        #1;
        n_cmp++;
        if (axi_bus.rready !== 1'b1) begin
          n_err++;
          $display("FAIL beat_rready addr=%h beat=%0d rready=%b required=1", a, b, axi_bus.rready);
        end
        tick();
        cpu.ibus_flush_2 = 1'b0;
        cpu.inv_icache   = 1'b0;
      end
      axi_bus.rvalid = 1'b0;
      axi_bus.rlast  = 1'b0;
      #1;
      n_cmp++;
      if (cpu.ibus_rddata_vld !== (killed ? 1'b0 : 1'b1) || cpu.ibus_stall !== 1'b0 ||
          (!killed && cpu.ibus_rddata !== mem_word(a))) begin
        n_err++;
        $display("FAIL fill_resp addr=%h vld=%b stall=%b data=%h required vld=%b stall=0 data=%h",
                 a, cpu.ibus_rddata_vld, cpu.ibus_stall, cpu.ibus_rddata, !killed, mem_word(a));
      end
      if (!exp_hit) m_fill(a);
      if (inv_last) m_inv(a);
    end
  endtask

  task automatic test_reset;
    drive_idle();
    rst = 1'b0;
    repeat (3) tick();
    #1;
    n_cmp++;
    if (cpu.ibus_ready !== 1'b0 || cpu.ibus_stall !== 1'b0 || cpu.ibus_rddata_vld !== 1'b0 ||
        cpu.ibus_rddata !== 32'h0 || axi_bus.arvalid !== 1'b0 || axi_bus.rready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state ready=%b stall=%b vld=%b data=%h arvalid=%b rready=%b required all 0",
               cpu.ibus_ready, cpu.ibus_stall, cpu.ibus_rddata_vld, cpu.ibus_rddata,
               axi_bus.arvalid, axi_bus.rready);
    end
    n_cmp++;
    if (axi_bus.awvalid !== 1'b0 || axi_bus.wvalid !== 1'b0 || axi_bus.bready !== 1'b1) begin
      n_err++;
      $display("FAIL write_idle awvalid=%b wvalid=%b bready=%b required 0 0 1",
               axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready);
    end
    rst = 1'b1;
    tick();
    m_reset();
    n_cmp++;
    if (cpu.ibus_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset ready=%b required=1", cpu.ibus_ready);
    end
  endtask

  task automatic test_cold_miss;
    int unsigned b0;
    do_read(32'h0, -1, 1'b0);
    b0 = n_bursts;
    do_read(32'h4, -1, 1'b0);
    n_cmp++;
    if (n_bursts != b0) begin
      n_err++;
      $display("FAIL cold_hit_no_ar bursts=%0d required=%0d", n_bursts, b0);
    end
  endtask

  task automatic test_sequential;
    int unsigned b0;
    apply_reset();
    b0 = n_bursts;
    for (int unsigned i = 0; i < 16; i++) do_read(32'(4 * i), -1, 1'b0);
    n_cmp++;
    if (n_bursts - b0 != 2) begin
      n_err++;
      $display("FAIL seq_bursts bursts=%0d required=2", n_bursts - b0);
    end
  endtask

  // Eight back-to-back hits; the flush in the 4th response cycle kills that
  // response while the request presented in the same cycle is still served.
  task automatic test_back_to_back;
    bit exp_v;
    do_read(32'h0, -1, 1'b0);
    cpu.ibus_addr = 32'h0;
    cpu.ibus_read = 1'b1;
    tick();
    for (int unsigned i = 1; i <= 8; i++) begin
      cpu.ibus_addr    = 32'(4 * i);
      cpu.ibus_read    = (i < 8);
      cpu.ibus_flush_1 = (i == 4);
      exp_v = (i != 4);
      #1;
      n_cmp++;
      if (cpu.ibus_rddata_vld !== exp_v || cpu.ibus_stall !== 1'b0 ||
          (exp_v && cpu.ibus_rddata !== mem_word(32'(4 * (i - 1))))) begin
        n_err++;
        $display("FAIL b2b_%0d vld=%b stall=%b data=%h required vld=%b stall=0 data=%h",
                 i, cpu.ibus_rddata_vld, cpu.ibus_stall, cpu.ibus_rddata, exp_v,
                 mem_word(32'(4 * (i - 1))));
      end
      tick();
    end
    cpu.ibus_read = 1'b0;
    cpu.ibus_flush_1 = 1'b0;
  endtask

  task automatic test_conflict;
    int unsigned b0;
    apply_reset();
    for (int unsigned i = 0; i < 5; i++) do_read(32'(32'h1000 * i), -1, 1'b0);
    b0 = n_bursts;
    do_read(32'h1000, -1, 1'b0);
    n_cmp++;
    if (n_bursts != b0) begin
      n_err++;
      $display("FAIL conflict_survivor bursts=%0d required=%0d", n_bursts, b0);
    end
    do_read(32'h0, -1, 1'b0);
    n_cmp++;
    if (n_bursts != b0 + 1) begin
      n_err++;
      $display("FAIL conflict_evicted bursts=%0d required=%0d", n_bursts, b0 + 1);
    end
  endtask

  task automatic test_invalidate;
    int unsigned b0;
    do_read(32'h0, -1, 1'b0);
    cpu.inv_icache = 1'b1;
    cpu.inv_addr   = 32'h5010;
    tick();
    cpu.inv_icache = 1'b0;
    m_inv(32'h5010);
    do_read(32'h4, -1, 1'b0);
    cpu.inv_icache = 1'b1;
    cpu.inv_addr   = 32'h10;
    tick();
    cpu.inv_icache = 1'b0;
    m_inv(32'h10);
    b0 = n_bursts;
    do_read(32'h0, -1, 1'b0);
    n_cmp++;
    if (n_bursts != b0 + 1) begin
      n_err++;
      $display("FAIL inv_refetch bursts=%0d required=%0d", n_bursts, b0 + 1);
    end
    do_read(32'h6000, -1, 1'b1);
    do_read(32'h6004, -1, 1'b0);
  endtask

  task automatic test_flush;
    do_read(32'h100, 3, 1'b0);
    do_read(32'h104, -1, 1'b0);
  endtask

  task automatic test_reset_mid_refill;
    cpu.ibus_addr = 32'h200;
    cpu.ibus_read = 1'b1;
    tick();
    cpu.ibus_read = 1'b0;
    axi_bus.arready = 1'b1;
    tick();
    axi_bus.arready = 1'b0;
    for (int unsigned b = 0; b < 3; b++) begin
      axi_bus.rvalid = 1'b1;
      axi_bus.rdata  = mem_word(32'(32'h200 + 4 * b));
      tick();
    end
    axi_bus.rvalid = 1'b0;
    rst = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (axi_bus.arvalid !== 1'b0 || axi_bus.rready !== 1'b0 || cpu.ibus_stall !== 1'b0 ||
        cpu.ibus_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset arvalid=%b rready=%b stall=%b ready=%b required all 0",
               axi_bus.arvalid, axi_bus.rready, cpu.ibus_stall, cpu.ibus_ready);
    end
    rst = 1'b1;
    tick();
    m_reset();
    do_read(32'h200, -1, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    int fb;
    apply_reset();
    salt = $urandom;
    for (int unsigned n = 0; n < 300; n++) begin
      a = {17'h0, 3'($urandom_range(0, 5)), 5'h0, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 9) == 0) begin
        cpu.inv_icache = 1'b1;
        cpu.inv_addr   = a;
        tick();
        cpu.inv_icache = 1'b0;
        m_inv(a);
      end else begin
        fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
        do_read(a, fb, $urandom_range(0, 15) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_sequential();
    test_back_to_back();
    test_conflict();
    test_invalidate();
    test_flush();
    test_reset_mid_refill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
